stepper_move_ctrl: RTL
======================

Name: stepper_move_ctrl

Overview:
Move sequencer for the 4-phase stepper drive stage. Accepts a move command over a valid/ready handshake: direction, full/half-step mode, step count and step period. Produces the registered 4-bit coil pattern (control_out) at the commanded rate and tracks absolute position. Supports abort and optional holding torque when idle.

Parameters:
CNT_W, 16, width of step count
PER_W, 16, width of step period (clocks per step)
POS_W, 32, width of signed position counter (half-step units)
HOLD_EN, 1, 1 = keep last pattern energized in IDLE after a move; 0 = de-energize (0000) in IDLE

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  move command valid
cmd_ready  out  1  high only in IDLE
cmd_dir  in  1  1 = forward (index +), 0 = reverse
cmd_half  in  1  1 = half-step (index ±1), 0 = full-step (index ±2)
cmd_steps  in  CNT_W  number of steps; 0 = null move
cmd_period  in  PER_W  clocks between steps; values <2 are treated as 2
abort  in  1  stop the move at the next edge
control_out  out  4  coil pattern, registered
busy  out  1  high in RUN
done  out  1  one-cycle pulse at move end
aborted  out  1  last move ended by abort; held until the next accept
pos  out  POS_W  signed position, half-step units, wraps modulo 2^POS_W

Behaviour:
- Reset values: control_out=0000, busy=0, done=0, aborted=0, pos=0, phase idx=0, energized=0, state=IDLE, cmd_ready=1.
- Phase table, idx 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
  - idx wraps modulo 8.
  - Full-step adds ±2, so an odd idx stays odd (two-coil full-step). No realignment.
- States:
  - IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready at edge E0.
    - cmd_steps=0: stay IDLE; done=1 for the cycle after E0; no energize; aborted cleared.
    - cmd_steps>0: go to RUN; latch dir, half, steps and clamped period; energized=1; control_out=table[idx] after E0 (no step yet); aborted cleared.
  - RUN: busy=1, cmd_ready=0.
    - Period counter issues step k at edge E0+k*P, k=1..N.
    - Each step updates idx, control_out=table[new idx], and pos ±1 (half) or ±2 (full).
    - At the edge of step N: state→IDLE, done=1 for one cycle, busy=0, cmd_ready=1.
    - A back-to-back command may be accepted in that done cycle.
- abort:
  - In RUN, abort high at an edge: no step is taken at that edge, even if one is due. State→IDLE, done=1 one cycle, aborted=1. idx and pos keep their last stepped values.
  - abort in IDLE is ignored. abort and cmd_valid together in IDLE: the command is accepted.
- IDLE output: table[idx] if HOLD_EN=1 and energized; otherwise 0000.
- Reset mid-move: all state returns to reset values at that edge. Position is lost.
- Command inputs are ignored outside the accept cycle.

Decomposition:
- stepper_pkg holds:
  - state_t enum {IDLE, RUN}
  - PHASE_TABLE constant (8 x 4 bits)
  - Width defaults
  - next_idx(idx, dir, half) function
- One sub-module, step_phase_gen: owns the idx register, the table lookup and the registered control_out. Inputs: step_en, dir, half, clear, out_en.

Test Plan:
1. Reset held 2 cycles -> control_out=0000, cmd_ready=1, busy=0, done=0, pos=0.
2. Full, fwd, steps=4, period=3, from idx 0 -> 0001 after E0; 0010 @E0+3; 0100 @+6; 1000 @+9; 0001 @+12; done pulse @+12 only; pos=8; busy low from +12.
3. Half, reverse, steps=3, period=2, from idx 0 -> 0001, then 1001 @+2, 1000 @+4, 1100 @+6; pos=-3; done @+6.
4. Steps=10, period=4, abort asserted for the edge E0+9 -> exactly 2 steps taken, no step at +12; done @+9; aborted=1; pos=±2 (half) / ±4 (full); then a new accept clears aborted.
5. Steps=0 -> done one cycle after accept; control_out stays 0000 after reset; pos unchanged. Period=0 or 1 with steps=2 -> steps at E0+2 and E0+4.
6. HOLD_EN=0: after a completed move, control_out=0000 in IDLE. Reset asserted mid-RUN -> next cycle all outputs at reset values. A back-to-back command accepted in the done cycle starts its first step P cycles later.

Source files
------------

// File: rtl/stepper_move_ctrl_pkg.sv
// Shared types, phase table and index-stepping helper for the stepper move sequencer.
package stepper_move_ctrl_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PER_W_DEF = 16;
    localparam int POS_W_DEF = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Half-step sequence; even entries energize one coil, odd entries two.
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110,
        4'b0100, 4'b1100, 4'b1000, 4'b1001
    };

    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input logic       dir,
                                            input logic       half);
        logic [2:0] delta;
        delta = half ? 3'd1 : 3'd2;
        if (dir) begin
            next_idx = idx + delta;
        end else begin
            next_idx = idx - delta;
        end
    endfunction

endpackage

// File: rtl/stepper_move_ctrl_if.sv
// Move-command handshake bundle between a command source and the sequencer.
interface stepper_move_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int PER_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic             cmd_half;
    logic [CNT_W-1:0] cmd_steps;
    logic [PER_W-1:0] cmd_period;

    modport master (
        output cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_move_ctrl_step_phase_gen.sv
// Phase index register and registered coil pattern; pattern is forced to 0000 when out_en is low.
module step_phase_gen
    import stepper_move_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_clear,
    input  logic       i_step_en,
    input  logic       i_dir,
    input  logic       i_half,
    input  logic       i_out_en,
    output logic [3:0] o_control_out
);

    logic [2:0] r_idx;
    logic [3:0] r_control_out;
    logic [2:0] w_idx_next;

    // Index to be used after this edge.
    always_comb begin
        w_idx_next = r_idx;
        if (i_step_en) begin
            w_idx_next = next_idx(r_idx, i_dir, i_half);
        end else begin
            w_idx_next = r_idx;
        end
    end

    // Index and output pattern registers.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_idx         <= 3'd0;
            r_control_out <= 4'b0000;
        end else begin
            r_idx         <= w_idx_next;
            r_control_out <= i_out_en ? PHASE_TABLE[w_idx_next] : 4'b0000;
        end
    end

    assign o_control_out = r_control_out;

endmodule

// File: rtl/stepper_move_ctrl.sv
// Move sequencer: accepts a move command, issues steps every period clocks, tracks position.
module stepper_move_ctrl
    import stepper_move_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PER_W   = PER_W_DEF,
    parameter int POS_W   = POS_W_DEF,
    parameter bit HOLD_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    stepper_move_ctrl_if.slave cmd_if,
    input  logic             i_abort,
    output logic [3:0]       o_control_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic [POS_W-1:0] o_pos
);

    state_t           r_state;
    logic             r_dir;
    logic             r_half;
    logic [CNT_W-1:0] r_steps_left;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_cnt;
    logic [POS_W-1:0] r_pos;
    logic             r_done;
    logic             r_aborted;
    logic             r_energized;

    state_t           w_state;
    logic             w_dir;
    logic             w_half;
    logic [CNT_W-1:0] w_steps_left;
    logic [PER_W-1:0] w_period;
    logic [PER_W-1:0] w_cnt;
    logic [POS_W-1:0] w_pos;
    logic             w_done;
    logic             w_aborted;
    logic             w_energized;
    logic             w_step;
    logic             w_out_en;
    logic [POS_W-1:0] w_delta;

    // Next-state, step decision and command latch.
    always_comb begin
        w_state      = r_state;
        w_dir        = r_dir;
        w_half       = r_half;
        w_steps_left = r_steps_left;
        w_period     = r_period;
        w_cnt        = r_cnt;
        w_pos        = r_pos;
        w_done       = 1'b0;
        w_aborted    = r_aborted;
        w_energized  = r_energized;
        w_step       = 1'b0;
        w_delta      = r_half ? POS_W'(1) : POS_W'(2);
        case (r_state)
            IDLE: begin
                if (cmd_if.cmd_valid) begin
                    w_aborted = 1'b0;
                    if (cmd_if.cmd_steps == CNT_W'(0)) begin
                        w_done = 1'b1;
                    end else begin
                        w_state      = RUN;
                        w_dir        = cmd_if.cmd_dir;
                        w_half       = cmd_if.cmd_half;
                        w_steps_left = cmd_if.cmd_steps;
                        w_period     = (cmd_if.cmd_period < PER_W'(2)) ? PER_W'(2) : cmd_if.cmd_period;
                        w_cnt        = PER_W'(1);
                        w_energized  = 1'b1;
                    end
                end else begin
                    w_state = IDLE;
                end
            end
            RUN: begin
                // Abort wins over a step that happens to fall due on the same edge.
                if (i_abort) begin
                    w_state   = IDLE;
                    w_done    = 1'b1;
                    w_aborted = 1'b1;
                end else if (r_cnt == r_period) begin
                    w_step       = 1'b1;
                    w_cnt        = PER_W'(1);
                    w_pos        = r_dir ? (r_pos + w_delta) : (r_pos - w_delta);
                    w_steps_left = r_steps_left - CNT_W'(1);
                    if (r_steps_left == CNT_W'(1)) begin
                        w_state = IDLE;
                        w_done  = 1'b1;
                    end else begin
                        w_state = RUN;
                    end
                end else begin
                    w_cnt = r_cnt + PER_W'(1);
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
        w_out_en = (w_state == RUN) || (HOLD_EN && w_energized);
    end

    // Sequencer registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_dir        <= 1'b0;
            r_half       <= 1'b0;
            r_steps_left <= '0;
            r_period     <= '0;
            r_cnt        <= '0;
            r_pos        <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_energized  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_dir        <= w_dir;
            r_half       <= w_half;
            r_steps_left <= w_steps_left;
            r_period     <= w_period;
            r_cnt        <= w_cnt;
            r_pos        <= w_pos;
            r_done       <= w_done;
            r_aborted    <= w_aborted;
            r_energized  <= w_energized;
        end
    end

    step_phase_gen u_phase (
        .i_clk         (i_clk),
        .i_clear       (i_reset),
        .i_step_en     (w_step),
        .i_dir         (r_dir),
        .i_half        (r_half),
        .i_out_en      (w_out_en),
        .o_control_out (o_control_out)
    );

    assign cmd_if.cmd_ready = (r_state == IDLE);
    assign o_busy           = (r_state == RUN);
    assign o_done           = r_done;
    assign o_aborted        = r_aborted;
    assign o_pos            = r_pos;

endmodule
